// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states, access sizes.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  // Unused funct3 codes (011, 110, 111) fall into the word case.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
interface lsu_if;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        lsu_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output lsu_busy, lsu_done, lsu_rdata, lsu_err, lsu_misalign,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  lsu_busy, lsu_done, lsu_rdata, lsu_err, lsu_misalign,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: byte enables, store replication, load extraction/extension.
// MISALIGN_TRAP_EN enables the misaligned-access trap flag.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_trap
);

  acc_size_e   w_size;
  logic [1:0]  w_lane;
  logic [31:0] w_shifted;
  logic        w_sext;

  assign w_size = f3_size(i_funct3);
  assign w_sext = ~i_funct3[2];

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    w_lane  = 2'b00;
    case (w_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        w_lane  = i_addr_lo;
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        w_lane  = {i_addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign w_shifted = i_rdata >> {w_lane, 3'b000};

  always_comb begin
    o_rdata = w_shifted;
    case (w_size)
      SZ_BYTE: o_rdata = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_rdata = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign o_trap = ((w_size == SZ_HALF) && i_addr_lo[0]) ||
                  ((w_size == SZ_WORD) && (i_addr_lo != 2'b00));
`else
  assign o_trap = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid bus transfer per request, with bus timeout.
// Optional misaligned-access trap via MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic             r_done;
  logic             r_err;
  logic             r_misalign;
  logic [31:0]      r_rdata;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic             w_idle;
  logic [2:0]       w_funct3;
  logic [1:0]       w_addr_lo;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;
  logic             w_trap;
  logic [CNT_W:0]   w_cnt_nxt;
  logic             w_timeout;

  assign w_idle = (r_state == S_IDLE);

  // Lane logic sees the incoming request in IDLE and the latched one afterwards.
  assign w_funct3  = w_idle ? bus.lsu_funct3     : r_funct3;
  assign w_addr_lo = w_idle ? bus.lsu_addr[1:0]  : r_addr_lo;

  lsu_align u_align (
    .i_funct3  (w_funct3),
    .i_addr_lo (w_addr_lo),
    .i_wdata   (bus.lsu_wdata),
    .i_rdata   (bus.mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_trap    (w_trap)
  );

  assign w_cnt_nxt = {1'b0, r_cnt} + 1'b1;
  assign w_timeout = (BUS_TIMEOUT != 0) && (w_cnt_nxt == (CNT_W+1)'(BUS_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_misalign  <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.lsu_req) begin
            r_funct3  <= bus.lsu_funct3;
            r_addr_lo <= bus.lsu_addr[1:0];
            if (w_trap) begin
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_cnt       <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.lsu_we;
              r_mem_be    <= w_be;
              r_mem_addr  <= {bus.lsu_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            if (r_mem_we) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= w_cnt_nxt[CNT_W-1:0];
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            r_rdata <= w_rdata;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_nxt[CNT_W-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.lsu_busy     = ~w_idle;
  assign bus.lsu_done     = r_done;
  assign bus.lsu_err      = r_err;
  assign bus.lsu_misalign = r_misalign;
  assign bus.lsu_rdata    = r_rdata;
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_be       = r_mem_be;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus queues expected completions, monitors compare on lsu_done.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if ifa ();
  lsu_if ifb ();

  lsu #(.BUS_TIMEOUT(255)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  lsu #(.BUS_TIMEOUT(4))   dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_a   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && ifa.lsu_done) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_done: got lsu_done=1, expected 0");
      end else begin
        e = qa.pop_front();
        check("a_rdata", ifa.lsu_rdata, e.rdata);
        check("a_err", 32'(ifa.lsu_err), 32'(e.err));
        check("a_misalign", 32'(ifa.lsu_misalign), 32'(e.mis));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && ifb.lsu_done) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_done: got lsu_done=1, expected 0");
      end else begin
        e = qb.pop_front();
        check("b_rdata", ifb.lsu_rdata, e.rdata);
        check("b_err", 32'(ifb.lsu_err), 32'(e.err));
        check("b_misalign", 32'(ifb.lsu_misalign), 32'(e.mis));
      end
    end
  end

  // One complete transfer on dut_a; returns in the lsu_done cycle so the next call issues back-to-back.
  task automatic access_a(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int gnt_wait,
                          input logic [31:0] rd, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata);
    exp_t e;
    if (we) e.rdata = last_a;
    else begin
      e.rdata = exp_rd;
      last_a  = exp_rd;
    end
    e.err = 1'b0;
    e.mis = 1'b0;
    qa.push_back(e);
    ifa.lsu_req    = 1'b1;
    ifa.lsu_we     = we;
    ifa.lsu_funct3 = f3;
    ifa.lsu_addr   = addr;
    ifa.lsu_wdata  = wdata;
    step();
    ifa.lsu_req   = 1'b0;
    ifa.lsu_wdata = 32'h5A5A_5A5A;
    for (int i = 0; i <= gnt_wait; i++) begin
      check({name, "_mem_req"},   32'(ifa.mem_req), 32'd1);
      check({name, "_busy"},      32'(ifa.lsu_busy), 32'd1);
      check({name, "_mem_we"},    32'(ifa.mem_we), 32'(we));
      check({name, "_mem_be"},    32'(ifa.mem_be), 32'(exp_be));
      check({name, "_mem_addr"},  ifa.mem_addr, exp_maddr);
      check({name, "_mem_wdata"}, ifa.mem_wdata, exp_mwdata);
      if (i == gnt_wait) ifa.mem_gnt = 1'b1;
      step();
    end
    ifa.mem_gnt = 1'b0;
    check({name, "_mem_req_dropped"}, 32'(ifa.mem_req), 32'd0);
    if (!we) begin
      check({name, "_busy_wait"}, 32'(ifa.lsu_busy), 32'd1);
      check({name, "_no_early_done"}, 32'(ifa.lsu_done), 32'd0);
      ifa.mem_rvalid = 1'b1;
      ifa.mem_rdata  = rd;
      step();
      ifa.mem_rvalid = 1'b0;
      ifa.mem_rdata  = 32'hDEAD_0000;
    end
    check({name, "_done"}, 32'(ifa.lsu_done), 32'd1);
    check({name, "_busy_end"}, 32'(ifa.lsu_busy), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e;
    {ifa.lsu_req, ifa.lsu_we, ifa.mem_gnt, ifa.mem_rvalid} = '0;
    {ifb.lsu_req, ifb.lsu_we, ifb.mem_gnt, ifb.mem_rvalid} = '0;
    ifa.lsu_funct3 = '0; ifa.lsu_addr = '0; ifa.lsu_wdata = '0; ifa.mem_rdata = '0;
    ifb.lsu_funct3 = '0; ifb.lsu_addr = '0; ifb.lsu_wdata = '0; ifb.mem_rdata = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_busy",      32'(ifa.lsu_busy), 32'd0);
    check("rst_done",      32'(ifa.lsu_done), 32'd0);
    check("rst_rdata",     ifa.lsu_rdata, 32'd0);
    check("rst_err",       32'(ifa.lsu_err), 32'd0);
    check("rst_misalign",  32'(ifa.lsu_misalign), 32'd0);
    check("rst_mem_req",   32'(ifa.mem_req), 32'd0);
    check("rst_mem_we",    32'(ifa.mem_we), 32'd0);
    check("rst_mem_be",    32'(ifa.mem_be), 32'd0);
    check("rst_mem_addr",  ifa.mem_addr, 32'd0);
    check("rst_mem_wdata", ifa.mem_wdata, 32'd0);

    // Stray handshakes while idle must be ignored
    ifa.mem_gnt = 1'b1; ifa.mem_rvalid = 1'b1; ifa.mem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    ifa.mem_gnt = 1'b0; ifa.mem_rvalid = 1'b0;
    check("idle_stray_busy",  32'(ifa.lsu_busy), 32'd0);
    check("idle_stray_rdata", ifa.lsu_rdata, 32'd0);

    // Back-to-back directed transfers
    access_a("sw",     1'b1, F3_SW,  32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0,         32'h0,         4'b1111, 32'h0000_0100, 32'hDEAD_BEEF);
    access_a("lb",     1'b0, F3_LB,  32'h0000_0203, 32'h0,         0, 32'h8011_2233, 32'hFFFF_FF80, 4'b1000, 32'h0000_0200, 32'h0);
    access_a("lbu",    1'b0, F3_LBU, 32'h0000_0203, 32'h0,         0, 32'h8011_2233, 32'h0000_0080, 4'b1000, 32'h0000_0200, 32'h0);
    access_a("sh_gnt5",1'b1, F3_SH,  32'h0000_0002, 32'h0000_ABCD, 5, 32'h0,         32'h0,         4'b1100, 32'h0000_0000, 32'hABCD_ABCD);
    access_a("lhu",    1'b0, F3_LHU, 32'h0000_0202, 32'h0,         2, 32'h9ABC_1234, 32'h0000_9ABC, 4'b1100, 32'h0000_0200, 32'h0);
    access_a("sb",     1'b1, F3_SB,  32'h0000_0101, 32'h1234_5678, 0, 32'h0,         32'h0,         4'b0010, 32'h0000_0100, 32'h7878_7878);
    access_a("lw",     1'b0, F3_LW,  32'h0000_0300, 32'h0,         0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0000_0300, 32'h0);
    access_a("f3_011", 1'b0, 3'b011, 32'h0000_0304, 32'h0,         0, 32'h1122_3344, 32'h1122_3344, 4'b1111, 32'h0000_0304, 32'h0);
    access_a("lb_pos", 1'b0, F3_LB,  32'h0000_0001, 32'h0,         1, 32'h0000_7F00, 32'h0000_007F, 4'b0010, 32'h0000_0000, 32'h0);

    // Misaligned halfword load
`ifdef MISALIGN_TRAP_EN
    e.rdata = last_a; e.err = 1'b0; e.mis = 1'b1;
    qa.push_back(e);
    ifa.lsu_req = 1'b1; ifa.lsu_we = 1'b0; ifa.lsu_funct3 = F3_LH; ifa.lsu_addr = 32'h0000_0001;
    step();
    ifa.lsu_req = 1'b0;
    check("trap_mem_req",  32'(ifa.mem_req), 32'd0);
    check("trap_busy",     32'(ifa.lsu_busy), 32'd0);
    check("trap_done",     32'(ifa.lsu_done), 32'd1);
    check("trap_misalign", 32'(ifa.lsu_misalign), 32'd1);
    step();
    check("trap_done_pulse", 32'(ifa.lsu_done), 32'd0);
    check("trap_mem_req_after", 32'(ifa.mem_req), 32'd0);
`else
    access_a("lh_mis", 1'b0, F3_LH, 32'h0000_0001, 32'h0, 0, 32'h1234_8765, 32'hFFFF_8765, 4'b0011, 32'h0000_0000, 32'h0);
    step();
`endif

    // Bus timeout on the BUS_TIMEOUT=4 instance: grant never arrives
    e.rdata = 32'h0; e.err = 1'b1; e.mis = 1'b0;
    qb.push_back(e);
    ifb.lsu_req = 1'b1; ifb.lsu_we = 1'b0; ifb.lsu_funct3 = F3_LW; ifb.lsu_addr = 32'h0000_0400;
    step();
    ifb.lsu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_mem_req_held", 32'(ifb.mem_req), 32'd1);
      check("to_no_done",      32'(ifb.lsu_done), 32'd0);
      step();
    end
    check("to_done",     32'(ifb.lsu_done), 32'd1);
    check("to_err",      32'(ifb.lsu_err), 32'd1);
    check("to_mem_req",  32'(ifb.mem_req), 32'd0);
    check("to_busy",     32'(ifb.lsu_busy), 32'd0);
    step();
    check("to_done_pulse", 32'(ifb.lsu_done), 32'd0);
    check("to_err_pulse",  32'(ifb.lsu_err), 32'd0);
    check("to_mem_req_after", 32'(ifb.mem_req), 32'd0);

    // Reset while the request is outstanding in REQ
    ifa.lsu_req = 1'b1; ifa.lsu_we = 1'b1; ifa.lsu_funct3 = F3_SW; ifa.lsu_addr = 32'h0000_0600;
    step();
    ifa.lsu_req = 1'b0;
    check("rreq_mem_req_before", 32'(ifa.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rreq_mem_req", 32'(ifa.mem_req), 32'd0);
    check("rreq_busy",    32'(ifa.lsu_busy), 32'd0);
    last_a = '0;
    step();
    rst = 1'b0;
    ifa.mem_gnt = 1'b1;
    step();
    ifa.mem_gnt = 1'b0;
    check("rreq_late_gnt_done", 32'(ifa.lsu_done), 32'd0);
    check("rreq_late_gnt_busy", 32'(ifa.lsu_busy), 32'd0);

    // Load with a nonzero result first, then reset while in WAIT
    access_a("lw_pre", 1'b0, F3_LW, 32'h0000_0500, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'h0000_0500, 32'h0);
    ifa.lsu_req = 1'b1; ifa.lsu_we = 1'b0; ifa.lsu_funct3 = F3_LW; ifa.lsu_addr = 32'h0000_0504;
    step();
    ifa.lsu_req = 1'b0;
    ifa.mem_gnt = 1'b1;
    step();
    ifa.mem_gnt = 1'b0;
    check("rwait_busy_before", 32'(ifa.lsu_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rwait_mem_req", 32'(ifa.mem_req), 32'd0);
    check("rwait_busy",    32'(ifa.lsu_busy), 32'd0);
    check("rwait_rdata",   ifa.lsu_rdata, 32'd0);
    last_a = '0;
    step();
    rst = 1'b0;
    ifa.mem_rvalid = 1'b1; ifa.mem_rdata = 32'h7777_7777;
    step();
    ifa.mem_rvalid = 1'b0;
    check("rwait_late_rvalid_done",  32'(ifa.lsu_done), 32'd0);
    check("rwait_late_rvalid_rdata", ifa.lsu_rdata, 32'd0);
    step();
    check("rwait_still_idle", 32'(ifa.lsu_busy), 32'd0);

    // Recovery after reset
    access_a("lw_post", 1'b0, F3_LW, 32'h0000_0700, 32'h0, 0, 32'h55AA_55AA, 32'h55AA_55AA, 4'b1111, 32'h0000_0700, 32'h0);
    step();
    step();

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
